// File: rtl/serial_adder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | serial_adder_pkg                                                    |
// | Shared state encoding and default width for the bit-serial adder.   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int c_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/FullAdder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | FullAdder                                                           |
// | One-bit full-adder cell used as the serial adder's bit slice.       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module FullAdder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_Cin,
  output logic o_Sum,
  output logic o_Cout
);

  assign o_Sum  = i_A ^ i_B ^ i_Cin;
  assign o_Cout = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);

endmodule : FullAdder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | serial_adder                                                        |
// | LSB-first bit-serial adder: one FullAdder slice, registered carry.  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int               c_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   w_sum_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_accept;
  logic               w_last;

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == c_LAST_CNT);

  FullAdder u_fa (
    .i_A    (r_a_sh[0]),
    .i_B    (r_b_sh[0]),
    .i_Cin  (r_carry),
    .o_Sum  (w_fa_sum),
    .o_Cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_fa_sum;
    end else begin : g_sum_wn
      assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = i_start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      RUN:     o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= i_a;
      r_b_sh   <= i_b;
      r_sum_sh <= '0;
      r_carry  <= i_cin;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_fa_cout;
      r_cnt    <= r_cnt + c_CNT_W'(1);
    end
  end

  // Result registers hold after DONE until the next accepted start.
  assign o_sum  = r_sum_sh;
  assign o_cout = r_carry;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_serial_adder                                                     |
// | Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8), .i_cin(cin8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1), .i_cin(cin1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
  );

  // Issues one start on the 8-bit DUT and waits (bounded) for o_done.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output int lat, output int busy_cnt,
                         output logic [7:0] s, output logic co);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; busy_cnt = 0;
    if (busy8) busy_cnt++;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) busy_cnt++;
    end
    s = sum8; co = cout8;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
    start1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #2;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum8 got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout8 got %b want 0", cout8); end
    checks++; if ({busy1, done1, sum1, cout1} !== 4'b0) begin
      errors++; $display("FAIL reset_dut1 got %b want 0000", {busy1, done1, sum1, cout1});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy8, done8} !== 2'b00) begin
      errors++; $display("FAIL idle_no_start got busy/done %b want 00", {busy8, done8});
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ex [3] = '{9'h096, 9'h100, 9'h1FF};
    int lat, bc; logic [7:0] s; logic co;
    for (int i = 0; i < 3; i++) begin
      run_op8(ta[i], tb[i], tc[i], lat, bc, s, co);
      checks++; if (lat !== 8) begin errors++; $display("FAIL dir%0d_latency got %0d want 8", i, lat); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want 8", i, bc); end
      checks++; if ({co, s} !== ex[i]) begin
        errors++; $display("FAIL dir%0d_result got %h want %h", i, {co, s}, ex[i]);
      end
    end
    @(posedge clk); #1;
    checks++; if ({busy8, done8} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle got busy/done %b want 00", {busy8, done8});
    end
    checks++; if ({cout8, sum8} !== 9'h1FF) begin
      errors++; $display("FAIL result_hold got %h want 1ff", {cout8, sum8});
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [7:0] s, ra, rb; logic co, rc; logic [8:0] ex;
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      run_op8(ra, rb, rc, lat, bc, s, co);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rnd%0d_latency got %0d want 8", i, lat); end
      checks++; if ({co, s} !== ex) begin
        errors++; $display("FAIL rnd%0d_result %h+%h+%b got %h want %h", i, ra, rb, rc, {co, s}, ex);
      end
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0, done_edge = -1;
    logic [8:0] got = '0;
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
    for (int e = 3; e <= 30; e++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (done_edge < 0) begin done_edge = e; got = {cout8, sum8}; end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    checks++; if (done_edge !== 8) begin errors++; $display("FAIL ignore_latency got %0d want 8", done_edge); end
    checks++; if (got !== 9'h002) begin errors++; $display("FAIL ignore_result got %h want 002", got); end
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, cout8, sum8} !== 11'h0) begin
      errors++; $display("FAIL async_reset got busy/done/cout/sum %b want all 0", {busy8, done8, cout8, sum8});
    end
    #2 rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL post_reset_activity got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int e = 0, d = 1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    while (!done8 && e < 40) begin @(posedge clk); #1; e++; end
    checks++; if (e !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", e); end
    checks++; if ({cout8, sum8} !== 9'h047) begin
      errors++; $display("FAIL b2b_first_result got %h want 047", {cout8, sum8});
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++; if ({busy8, done8} !== 2'b10) begin
      errors++; $display("FAIL b2b_accept got busy/done %b want 10", {busy8, done8});
    end
    while (!done8 && d < 40) begin @(posedge clk); #1; d++; end
    checks++; if (d !== 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", d); end
    checks++; if ({cout8, sum8} !== 9'h100) begin
      errors++; $display("FAIL b2b_second_result got %h want 100", {cout8, sum8});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    logic [2:0] v;
    int ex;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      ex = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(posedge clk); #1;
      start1 = 1'b0;
      checks++; if ({busy1, done1} !== 2'b10) begin
        errors++; $display("FAIL w1_%0d_run got busy/done %b want 10", i, {busy1, done1});
      end
      @(posedge clk); #1;
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL w1_%0d_done got %b want 1", i, done1); end
      checks++; if ({cout1, sum1} !== 2'(ex)) begin
        errors++; $display("FAIL w1_%0d_result got %b want %b", i, {cout1, sum1}, 2'(ex));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
`default_nettype wire
